// File: rtl/instr_capture_fifo.sv
// Purpose : sync + debounce a parallel instrument input, timestamp each change of the
//           filtered value and queue {ts, value} events in a first-word-fall-through FIFO.
// Latency : stable input to rd_valid = STABLE_CYCLES+3 edges (empty FIFO).
// Backpressure: none upstream; a push into a full FIFO without a same-edge pop is
//           dropped and sets the sticky overflow flag.
// Ports   : ACLK/ARESET (sync, active-high); inst_in async instrument bus; enable gates
//           pushes and the timestamp; pop consumes the head; clr_overflow clears the
//           sticky flag; rd_valid/rd_data expose the head; level = entries held.
// Option  : INSTR_CAPTURE_TIMESTAMP_EN builds the timestamp counter; without it the ts
//           field of every entry is 0 (port widths unchanged).
module instr_capture_fifo #(
  parameter int DATA_W        = 16,
  parameter int TS_W          = 16,
  parameter int DEPTH         = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [DATA_W-1:0]        inst_in,
  input  logic                     enable,
  input  logic                     pop,
  input  logic                     clr_overflow,
  output logic                     rd_valid,
  output logic [TS_W+DATA_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int EW = TS_W + DATA_W;

  // ---------------- synchroniser + debounce filter ----------------
  logic [DATA_W-1:0] sync1, s, s_prev;
  logic [CW-1:0]     cnt;
  logic              changed;
  logic              accept;
  logic              acc_vld;
  logic [DATA_W-1:0] acc_val;
  logic [DATA_W-1:0] last_accepted;

  assign changed = (s != s_prev);

  // Accept on the edge where the run counter reaches STABLE_CYCLES. A change restarts
  // the run at 1, which already satisfies a filter depth of one.
  always_comb begin
    accept = 1'b0;
    if (changed) accept = (STABLE_CYCLES == 1);
    else         accept = (cnt == CW'(STABLE_CYCLES - 1));
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sync1   <= '0;
      s       <= '0;
      s_prev  <= '0;
      cnt     <= '0;
      acc_vld <= 1'b0;
      acc_val <= '0;
    end else begin
      sync1   <= inst_in;
      s       <= sync1;
      s_prev  <= s;
      if (changed)                      cnt <= CW'(1);
      else if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + CW'(1);
      acc_vld <= accept;
      acc_val <= s;
    end
  end

  // ---------------- change detection ----------------
  logic ev;
  logic push;

  assign ev   = acc_vld && (acc_val != last_accepted);
  // last_accepted tracks the filtered value even while disabled so re-enabling
  // never emits a stale event.
  assign push = ev && enable;

  always_ff @(posedge ACLK) begin
    if (ARESET)  last_accepted <= '0;
    else if (ev) last_accepted <= acc_val;
  end

  // ---------------- timestamp ----------------
  logic [TS_W-1:0] ts_val;

`ifdef INSTR_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge ACLK) begin
    if (ARESET)      ts_cnt <= '0;
    else if (enable) ts_cnt <= ts_cnt + TS_W'(1);
  end

  assign ts_val = ts_cnt;
`else
  assign ts_val = '0;
`endif

  // ---------------- FWFT FIFO ----------------
  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full;
  logic          do_pop, do_wr, drop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  // A same-edge pop frees the slot, so a full FIFO still takes the push.
  assign do_wr  = push && (!full || do_pop);
  assign drop   = push && full && !do_pop;

  always_ff @(posedge ACLK) begin
    if (do_wr && !ARESET) mem[wr_ptr[AW-1:0]] <= {ts_val, acc_val};
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      // A drop on the same edge as a clear keeps the flag set.
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign level    = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_instr_capture_fifo.sv
module tb_instr_capture_fifo;

  localparam int DATA_W = 16;
  localparam int TS_W   = 16;
  localparam int DEPTH  = 16;
  localparam int S      = 4;
  localparam int EW     = TS_W + DATA_W;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic [DATA_W-1:0] inst_in = '0;
  logic              enable = 1'b0;
  logic              pop = 1'b0;
  logic              clr_overflow = 1'b0;
  logic              rd_valid;
  logic [EW-1:0]     rd_data;
  logic [4:0]        level;
  logic              overflow;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  instr_capture_fifo #(
    .DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH), .STABLE_CYCLES(S)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .inst_in(inst_in), .enable(enable), .pop(pop),
    .clr_overflow(clr_overflow), .rd_valid(rd_valid), .rd_data(rd_data),
    .level(level), .overflow(overflow)
  );

  // ---------------- reference model ----------------
  // Input samples form runs; a run reaching S samples yields an accepted value whose
  // event lands 3 edges later (2 sync stages + 1 registered accept).
  typedef struct { int due; logic [DATA_W-1:0] val; } acc_t;
  logic [EW-1:0]     mq[$];
  acc_t              dq[$];
  int                cyc = 0;
  logic [DATA_W-1:0] run_val = '0;
  int                run_len = S + 1;
  logic [TS_W-1:0]   m_ts = '0;
  logic [DATA_W-1:0] m_last = '0;
  logic              m_ovf = 1'b0;
  int                ts_req = 0;
  int                ts_ack = 0;
  logic [TS_W-1:0]   ts_req_val = '0;

  always @(posedge ACLK) begin : model
    logic [EW-1:0] ent;
    bit m_push, m_pop, dropped;
    cyc++;
    if (ts_req != ts_ack) begin
      m_ts   = ts_req_val;
      ts_ack = ts_req;
    end
    if (ARESET) begin
      mq.delete(); dq.delete();
      run_val = '0; run_len = S + 1;
      m_ts = '0; m_last = '0; m_ovf = 1'b0;
    end else begin
      m_push = 0; dropped = 0; ent = '0;
      m_pop  = pop && (mq.size() != 0);
      if (dq.size() != 0 && dq[0].due == cyc) begin
        if (dq[0].val != m_last) begin
          m_last = dq[0].val;
          if (enable) begin
            m_push = 1;
`ifdef INSTR_CAPTURE_TIMESTAMP_EN
            ent = {m_ts, dq[0].val};
`else
            ent = {{TS_W{1'b0}}, dq[0].val};
`endif
          end
        end
        void'(dq.pop_front());
      end
      if (inst_in == run_val) begin
        if (run_len <= S) run_len++;
      end else begin
        run_val = inst_in;
        run_len = 1;
      end
      if (run_len == S) dq.push_back('{cyc + 3, run_val});
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(ent);
        else dropped = 1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      if (enable) m_ts++;
    end
  end

  function automatic logic [EW-1:0] m_head();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  task automatic do_reset(input logic en);
    @(negedge ACLK);
    ARESET = 1'b1; inst_in = '0; enable = en; pop = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset(1'b1);
    inst_in = 16'h0005;
    repeat (10) @(negedge ACLK);
    ARESET = 1'b1; inst_in = '0;
    repeat (2) @(negedge ACLK);
    total++;
    if (rd_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0 || rd_data !== '0) begin
      bad++;
      $display("FAIL reset_state: got v=%0b l=%0d o=%0b d=%h, need v=0 l=0 o=0 d=0",
               rd_valid, level, overflow, rd_data);
    end
    ARESET = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ACLK);
      total++;
      if (rd_valid !== 1'b0 || level !== 5'd0) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: got v=%0b l=%0d, need v=0 l=0", i, rd_valid, level);
      end
    end
  endtask

  task automatic test_single_event();
    int n;
    logic [EW-1:0] exp;
`ifdef INSTR_CAPTURE_TIMESTAMP_EN
    exp = {16'd16, 16'h00A5};
`else
    exp = {16'd0, 16'h00A5};
`endif
    do_reset(1'b1);
    repeat (10) @(negedge ACLK);
    inst_in = 16'h00A5;
    for (n = 1; n <= 20; n++) begin
      @(negedge ACLK);
      if (rd_valid) break;
    end
    total++;
    if (n !== 7) begin
      bad++;
      $display("FAIL single_latency: got %0d edges, need 7", n);
    end
    total++;
    if (rd_data !== exp || rd_data !== m_head() || level !== 5'd1) begin
      bad++;
      $display("FAIL single_data: got d=%h l=%0d, need d=%h l=1", rd_data, level, exp);
    end
    pop = 1'b1;
    @(negedge ACLK);
    pop = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || level !== 5'd0) begin
      bad++;
      $display("FAIL single_pop: got v=%0b l=%0d, need v=0 l=0", rd_valid, level);
    end
  endtask

  task automatic test_debounce();
    do_reset(1'b1);
    repeat (8) @(negedge ACLK);
    inst_in = 16'h0003;
    repeat (3) @(negedge ACLK);
    inst_in = 16'h0000;
    repeat (12) @(negedge ACLK);
    total++;
    if (level !== 5'd0 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL debounce_glitch: got l=%0d v=%0b, need l=0 v=0", level, rd_valid);
    end
    inst_in = 16'h0003;
    repeat (20) @(negedge ACLK);
    total++;
    if (level !== 5'd1 || rd_data[DATA_W-1:0] !== 16'h0003 || rd_data !== m_head()) begin
      bad++;
      $display("FAIL debounce_stable: got l=%0d d=%h, need l=1 value=0003 d=%h",
               level, rd_data, m_head());
    end
  endtask

  task automatic test_overflow();
    int exp_v;
    do_reset(1'b1);
    repeat (4) @(negedge ACLK);
    for (int v = 1; v <= 17; v++) begin
      inst_in = DATA_W'(v);
      repeat (6) @(negedge ACLK);
      if (v == 17) clr_overflow = 1'b1;   // clear coincides with the dropped push
      @(negedge ACLK);
      clr_overflow = 1'b0;
    end
    repeat (2) @(negedge ACLK);
    total++;
    if (level !== 5'd16 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_full: got l=%0d o=%0b, need l=16 o=1", level, overflow);
    end
    clr_overflow = 1'b1;
    @(negedge ACLK);
    clr_overflow = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: got o=%0b, need o=0", overflow);
    end
    inst_in = 16'd18;
    repeat (6) @(negedge ACLK);
    pop = 1'b1;
    @(negedge ACLK);
    pop = 1'b0;
    total++;
    if (level !== 5'd16 || overflow !== 1'b0 || rd_data[DATA_W-1:0] !== 16'd2) begin
      bad++;
      $display("FAIL ovf_push_pop: got l=%0d o=%0b head=%0d, need l=16 o=0 head=2",
               level, overflow, rd_data[DATA_W-1:0]);
    end
    pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_v = (i == 15) ? 18 : i + 2;
      total++;
      if (rd_data[DATA_W-1:0] !== DATA_W'(exp_v) || rd_data !== m_head()) begin
        bad++;
        $display("FAIL ovf_order[%0d]: got %h, need value %0d (model %h)",
                 i, rd_data, exp_v, m_head());
      end
      @(negedge ACLK);
    end
    pop = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || level !== 5'd0) begin
      bad++;
      $display("FAIL ovf_drain: got v=%0b l=%0d, need v=0 l=0", rd_valid, level);
    end
  endtask

  task automatic test_enable_gating();
    logic [EW-1:0] exp;
`ifdef INSTR_CAPTURE_TIMESTAMP_EN
    exp = {16'd18, 16'h0020};
`else
    exp = {16'd0, 16'h0020};
`endif
    do_reset(1'b0);
    inst_in = 16'h0010;
    repeat (12) @(negedge ACLK);
    enable = 1'b1;
    repeat (12) @(negedge ACLK);
    total++;
    if (level !== 5'd0 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL enable_stale: got l=%0d v=%0b, need l=0 v=0", level, rd_valid);
    end
    inst_in = 16'h0020;
    repeat (8) @(negedge ACLK);
    total++;
    if (level !== 5'd1 || rd_data !== exp || rd_data !== m_head()) begin
      bad++;
      $display("FAIL enable_ts_hold: got l=%0d d=%h, need l=1 d=%h", level, rd_data, exp);
    end
  endtask

  task automatic test_wrap_and_empty_pop();
`ifdef INSTR_CAPTURE_TIMESTAMP_EN
    do_reset(1'b1);
    repeat (4) @(negedge ACLK);
    inst_in = 16'h0007;
    repeat (6) @(negedge ACLK);
    force dut.ts_cnt = 16'hFFFF;
    ts_req_val = 16'hFFFF;
    ts_req++;
    #1 release dut.ts_cnt;
    @(negedge ACLK);
    total++;
    if (rd_data !== {16'hFFFF, 16'h0007} || rd_data !== m_head()) begin
      bad++;
      $display("FAIL wrap_max: got %h, need ffff0007", rd_data);
    end
    inst_in = 16'h0009;
    repeat (8) @(negedge ACLK);
    pop = 1'b1;
    @(negedge ACLK);
    pop = 1'b0;
    total++;
    if (rd_data !== {16'h0006, 16'h0009} || level !== 5'd1) begin
      bad++;
      $display("FAIL wrap_zero: got d=%h l=%0d, need d=00060009 l=1", rd_data, level);
    end
`endif
    do_reset(1'b1);
    pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      total++;
      if (level !== 5'd0 || rd_valid !== 1'b0 || rd_data !== '0) begin
        bad++;
        $display("FAIL empty_pop[%0d]: got l=%0d v=%0b d=%h, need l=0 v=0 d=0",
                 i, level, rd_valid, rd_data);
      end
    end
    inst_in = 16'h0011;
    repeat (6) @(negedge ACLK);
    @(negedge ACLK);
    total++;
    if (level !== 5'd1 || rd_data[DATA_W-1:0] !== 16'h0011) begin
      bad++;
      $display("FAIL empty_push_pop: got l=%0d d=%h, need l=1 value=0011", level, rd_data);
    end
    @(negedge ACLK);
    pop = 1'b0;
    total++;
    if (level !== 5'd0) begin
      bad++;
      $display("FAIL empty_drain: got l=%0d, need l=0", level);
    end
  endtask

  task automatic test_random();
    int hold;
    logic [DATA_W-1:0] vals [4];
    vals[0] = 16'h0000; vals[1] = 16'h0001; vals[2] = 16'h0055; vals[3] = 16'hA5A5;
    hold = 0;
    do_reset(1'b1);
    for (int c = 0; c < 1500; c++) begin
      @(negedge ACLK);
      total++;
      if (rd_valid !== (mq.size() != 0) || level !== 5'(mq.size()) ||
          overflow !== m_ovf || rd_data !== m_head()) begin
        bad++;
        $display("FAIL random cyc%0d: got v=%0b l=%0d o=%0b d=%h, need v=%0b l=%0d o=%0b d=%h",
                 c, rd_valid, level, overflow, rd_data,
                 mq.size() != 0, mq.size(), m_ovf, m_head());
      end
      if (hold == 0) begin
        inst_in = vals[$urandom_range(0, 3)];
        hold = $urandom_range(1, 7);
      end
      hold--;
      pop          = ($urandom_range(0, 5) == 0);
      enable       = ($urandom_range(0, 7) != 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      ARESET       = ($urandom_range(0, 499) == 0);
    end
    ARESET = 1'b0; pop = 1'b0; clr_overflow = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_debounce();
    test_overflow();
    test_enable_gating();
    test_wrap_and_empty_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
